// File: rtl/store_align_unit_pkg.sv
// Shared encodings for the store alignment path: access sizes, FSM states and lane helpers.
package store_align_unit_pkg;

  localparam logic [1:0] SIZE_W = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_B = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_RESP  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SIZE_W:  base_mask = 4'b1111;
      SIZE_H:  base_mask = 4'b0011;
      SIZE_B:  base_mask = 4'b0001;
      default: base_mask = 4'b0000;
    endcase
  endfunction

  // One byte enable bit becomes eight data bits.
  function automatic logic [63:0] byte_expand(input logic [7:0] m);
    for (int i = 0; i < 8; i++) byte_expand[i*8 +: 8] = {8{m[i]}};
  endfunction

endpackage

// File: rtl/store_align_unit_store_lane_shift.sv
// Combinational lane mapper: (offset, size, data) -> 8-lane mask, 64-bit lane data, split flag.
module store_lane_shift
  import store_align_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [7:0]  mask,
  output logic [63:0] shifted,
  output logic        split
);

  logic [63:0] raw;

  assign mask    = {4'b0000, base_mask(size)} << off;
  assign raw     = {32'h0, data} << {off, 3'b000};
  // Lanes not being written are forced to zero.
  assign shifted = raw & byte_expand(mask);
  assign split   = |mask[7:4];

endmodule

// File: rtl/store_align_unit.sv
// Store aligner: turns a byte-addressed store into one or two word-aligned write beats.
// Macro STORE_SPLIT_EN enables the second beat for word-crossing stores; otherwise they error out.
//
// state | meaning
// IDLE  | ready for a request
// BEAT0 | first (or only) write beat on the memory port
// BEAT1 | upper-word beat of a word-crossing store
// RESP  | done pulse
// ERR   | err pulse, nothing written
module store_align_unit
  import store_align_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  state_t      state, state_next;
  logic [7:0]  mask;
  logic [63:0] shifted;
  logic        split;
  logic        accept;

  store_lane_shift u_lane_shift (
    .off     (req_addr[1:0]),
    .size    (req_size),
    .data    (req_data),
    .mask    (mask),
    .shifted (shifted),
    .split   (split)
  );

  assign accept = (state == ST_IDLE) && req_valid;

`ifdef STORE_SPLIT_EN
  logic [31:0] hi_wdata;
  logic [3:0]  hi_be;
  logic        split_q;
`else
  logic unused_hi;
  assign unused_hi = ^{shifted[63:32], mask[7:4]};
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_size == SIZE_X) state_next = ST_ERR;
`ifdef STORE_SPLIT_EN
          else                    state_next = ST_BEAT0;
`else
          else if (split)         state_next = ST_ERR;
          else                    state_next = ST_BEAT0;
`endif
        end
      end
      ST_BEAT0: begin
`ifdef STORE_SPLIT_EN
        if (mem_ready) state_next = split_q ? ST_BEAT1 : ST_RESP;
`else
        if (mem_ready) state_next = ST_RESP;
`endif
      end
`ifdef STORE_SPLIT_EN
      ST_BEAT1: if (mem_ready) state_next = ST_RESP;
`endif
      ST_RESP: state_next = ST_IDLE;
      ST_ERR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready = (state == ST_IDLE);
  assign mem_valid = (state == ST_BEAT0) || (state == ST_BEAT1);
  assign done      = (state == ST_RESP);
  assign err       = (state == ST_ERR);

  // Beat registers only move on accept or on a completed first beat, so they hold under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
`ifdef STORE_SPLIT_EN
      hi_wdata  <= 32'h0;
      hi_be     <= 4'h0;
      split_q   <= 1'b0;
`endif
    end else if (accept) begin
      mem_addr  <= {req_addr[31:2], 2'b00};
      mem_wdata <= shifted[31:0];
      mem_be    <= mask[3:0];
`ifdef STORE_SPLIT_EN
      hi_wdata  <= shifted[63:32];
      hi_be     <= mask[7:4];
      split_q   <= split;
    end else if ((state == ST_BEAT0) && mem_ready && split_q) begin
      mem_addr  <= mem_addr + 32'd4;
      mem_wdata <= hi_wdata;
      mem_be    <= hi_be;
`endif
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Directed bench for store_align_unit; expectations follow STORE_SPLIT_EN when it is defined.
module tb_store_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;

  store_align_unit dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_size  (req_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    chk({tag, " valid"}, 64'(mem_valid), 64'd1);
    chk({tag, " addr"},  64'(mem_addr),  64'(a));
    chk({tag, " be"},    64'(mem_be),    64'(be));
    chk({tag, " wdata"}, 64'(mem_wdata), 64'(wd));
    chk({tag, " done"},  64'(done),      64'd0);
  endtask

  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = s;
  endtask

  // Single-beat store with 'stall' cycles of mem_ready low before the handshake.
  task automatic run_single(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] s, input logic [31:0] ea, input logic [3:0] ebe,
                            input logic [31:0] ewd, input int stall);
    present(a, d, s);
    mem_ready = (stall == 0);
    step();
    req_valid = 1'b0;
    req_data  = 32'hFFFF_FFFF;
    for (int i = 0; i < stall; i++) begin
      chk_beat({tag, " held"}, ea, ebe, ewd);
      step();
    end
    mem_ready = 1'b1;
    chk_beat(tag, ea, ebe, ewd);
    step();
    chk({tag, " done"},      64'(done),      64'd1);
    chk({tag, " idle valid"}, 64'(mem_valid), 64'd0);
    chk({tag, " busy ready"}, 64'(req_ready), 64'd0);
    step();
    chk({tag, " ready back"}, 64'(req_ready), 64'd1);
    chk({tag, " done end"},  64'(done),      64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    req_size  = 2'b00;
    mem_ready = 1'b0;
    step();
    step();
    chk("rst req_ready", 64'(req_ready), 64'd1);
    chk("rst mem_valid", 64'(mem_valid), 64'd0);
    chk("rst mem_addr",  64'(mem_addr),  64'd0);
    chk("rst mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst mem_be",    64'(mem_be),    64'd0);
    chk("rst done",      64'(done),      64'd0);
    chk("rst err",       64'(err),       64'd0);
    rst = 1'b0;
    step();

    run_single("sw100", 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 0);
    run_single("sb203", 32'h0000_0203, 32'h1234_56AB, 2'b10, 32'h0000_0200, 4'b1000, 32'hAB00_0000, 0);
    run_single("sh302", 32'h0000_0302, 32'h0000_CAFE, 2'b01, 32'h0000_0300, 4'b1100, 32'hCAFE_0000, 3);
    run_single("sh501", 32'h0000_0501, 32'h9876_BEEF, 2'b01, 32'h0000_0500, 4'b0110, 32'h00BE_EF00, 0);
    run_single("sb500", 32'h0000_0500, 32'h1234_56AB, 2'b10, 32'h0000_0500, 4'b0001, 32'h0000_00AB, 1);

    // Word-crossing SW at the top of the address space.
    present(32'hFFFF_FFFE, 32'h1122_3344, 2'b00);
    mem_ready = 1'b1;
    step();
    req_valid = 1'b0;
`ifdef STORE_SPLIT_EN
    chk_beat("split b0", 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000);
    step();
    chk_beat("split b1", 32'h0000_0000, 4'b0011, 32'h0000_1122);
    step();
    chk("split done",  64'(done),      64'd1);
    chk("split valid", 64'(mem_valid), 64'd0);
    step();
    chk("split ready", 64'(req_ready), 64'd1);
`else
    chk("cross err",   64'(err),       64'd1);
    chk("cross valid", 64'(mem_valid), 64'd0);
    step();
    chk("cross ready", 64'(req_ready), 64'd1);
    chk("cross err end", 64'(err),     64'd0);
    chk("cross valid2", 64'(mem_valid), 64'd0);
`endif

    // Illegal size.
    present(32'h0000_0100, 32'h5555_AAAA, 2'b11);
    step();
    req_valid = 1'b0;
    chk("ill err",   64'(err),       64'd1);
    chk("ill valid", 64'(mem_valid), 64'd0);
    chk("ill ready", 64'(req_ready), 64'd0);
    step();
    chk("ill ready back", 64'(req_ready), 64'd1);
    chk("ill err end",    64'(err),       64'd0);

    // Reset during a stalled BEAT0.
    present(32'h0000_0400, 32'h0BAD_F00D, 2'b00);
    mem_ready = 1'b0;
    step();
    req_valid = 1'b0;
    chk("abort beat", 64'(mem_valid), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_ready = 1'b1;
    chk("abort valid", 64'(mem_valid), 64'd0);
    chk("abort ready", 64'(req_ready), 64'd1);
    chk("abort done",  64'(done),      64'd0);
    chk("abort err",   64'(err),       64'd0);
    step();
    chk("abort done2",  64'(done),      64'd0);
    chk("abort err2",   64'(err),       64'd0);
    chk("abort valid2", 64'(mem_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
